// File: rtl/out_mismatch_monitor_pkg.sv
// Shared types and constants for the output mismatch monitor.
package out_mismatch_monitor_pkg;

  // Run-control states of the monitor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default width of every counter and sample-index timestamp.
  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/mismatch_lane.sv
// One compared output bit: mismatch detect, saturating error count and
// first-mismatch sample index.
module mismatch_lane
  import out_mismatch_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             ref_bit,
  input  logic             dut_bit,
  input  logic [CNT_W-1:0] sample_idx,
  input  logic             idx_sat,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_idx
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  assign mismatch = ref_bit ^ dut_bit;

  // Count mismatching samples and remember the index of the first one; once
  // the shared sample index has saturated it no longer names a real sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt   <= '0;
      first_idx <= ALL_ONES;
    end else if (clear) begin
      err_cnt   <= '0;
      first_idx <= ALL_ONES;
    end else if (sample_en && mismatch) begin
      if (err_cnt != ALL_ONES) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if ((first_idx == ALL_ONES) && !idx_sat) begin
        first_idx <= sample_idx;
      end
    end
  end

endmodule

// File: rtl/out_mismatch_monitor.sv
// Compares golden and DUT output vectors over a start/stop delimited run and
// reports sample/error counts, first-error index and per-lane statistics.
module out_mismatch_monitor
  import out_mismatch_monitor_pkg::*;
#(
  parameter int N_OUT = 2,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   sample_valid,
  input  logic [N_OUT-1:0]       ref_vec,
  input  logic [N_OUT-1:0]       dut_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       samples,
  output logic [CNT_W-1:0]       errors,
  output logic [CNT_W-1:0]       first_err,
  output logic [N_OUT*CNT_W-1:0] lane_errors,
  output logic [N_OUT*CNT_W-1:0] lane_first
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t            state;
  state_t            state_next;
  logic              enter_run;
  logic              sample_en;
  logic              samples_sat;
  logic              any_mismatch;
  logic [N_OUT-1:0]  lane_mismatch;
  logic [CNT_W-1:0]  errors_next;

  // Next-state decode; start is only honoured outside RUN, so start+stop in
  // RUN ends the run while start+stop elsewhere begins one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stop)  state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  assign enter_run    = (state != RUN) && (state_next == RUN);
  assign sample_en    = (state == RUN) && sample_valid;
  assign samples_sat  = (samples == ALL_ONES);
  assign any_mismatch = |lane_mismatch;

  // Error count after this edge; pass in DONE needs it for the stop-cycle sample.
  always_comb begin
    errors_next = errors;
    if (enter_run) begin
      errors_next = '0;
    end else if (sample_en && any_mismatch && (errors != ALL_ONES)) begin
      errors_next = errors + CNT_W'(1);
    end
  end

  // State register with registered status flags derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      pass  <= (state_next == DONE) && (errors_next == '0);
    end
  end

  // Whole-vector statistics: sample count, error count and first error index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samples   <= '0;
      errors    <= '0;
      first_err <= ALL_ONES;
    end else begin
      errors <= errors_next;
      if (enter_run) begin
        samples   <= '0;
        first_err <= ALL_ONES;
      end else if (sample_en) begin
        if (!samples_sat) begin
          samples <= samples + CNT_W'(1);
        end
        if (any_mismatch && (first_err == ALL_ONES) && !samples_sat) begin
          first_err <= samples;
        end
      end
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    mismatch_lane #(
      .CNT_W(CNT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .clear     (enter_run),
      .sample_en (sample_en),
      .ref_bit   (ref_vec[i]),
      .dut_bit   (dut_vec[i]),
      .sample_idx(samples),
      .idx_sat   (samples_sat),
      .mismatch  (lane_mismatch[i]),
      .err_cnt   (lane_errors[i*CNT_W +: CNT_W]),
      .first_idx (lane_first[i*CNT_W +: CNT_W])
    );
  end

endmodule
